// File: rtl/layer_argmax.sv
// Sequential arg-max over a captured zed vector, one neuron compared per cycle.
// Optional LAYER_ARGMAX_MARGIN_EN adds second-best tracking and the margin output.
module layer_argmax #(
    parameter int number_neuron = 10,
    parameter int resolution    = 8,
    localparam int IDX_W = (number_neuron > 1) ? $clog2(number_neuron) : 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [number_neuron-1:0][resolution-1:0] zed,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic                                     out_valid,
    input  logic                                     out_ready,
`ifdef LAYER_ARGMAX_MARGIN_EN
    output logic [resolution-1:0]                    margin,
`endif
    output logic [IDX_W-1:0]                         class_idx,
    output logic signed [resolution-1:0]             class_score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [resolution-1:0] MIN_VAL = {1'b1, {(resolution-1){1'b0}}};

    logic [1:0]                              state;
    logic [number_neuron-1:0][resolution-1:0] cap;
    logic signed [resolution-1:0]            best;
    logic [IDX_W-1:0]                        best_idx;
    logic [IDX_W-1:0]                        scan_idx;

    logic signed [resolution-1:0]            elem;
    logic signed [resolution-1:0]            nxt_best;
    logic [IDX_W-1:0]                        nxt_idx;
    logic                                    last;

`ifdef LAYER_ARGMAX_MARGIN_EN
    logic signed [resolution-1:0]            second;
    logic signed [resolution-1:0]            nxt_second;
    logic [resolution:0]                     diff;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign elem      = $signed(cap[scan_idx]);
    assign last      = (scan_idx == IDX_W'(number_neuron - 1));

    // Strict compare keeps the lowest index on ties; an equal element still lands in second.
    always_comb begin
        nxt_best = best;
        nxt_idx  = best_idx;
`ifdef LAYER_ARGMAX_MARGIN_EN
        nxt_second = second;
`endif
        if (elem > best) begin
            nxt_best = elem;
            nxt_idx  = scan_idx;
`ifdef LAYER_ARGMAX_MARGIN_EN
            nxt_second = best;
`endif
        end
`ifdef LAYER_ARGMAX_MARGIN_EN
        else if (elem > second) begin
            nxt_second = elem;
        end
`endif
    end

`ifdef LAYER_ARGMAX_MARGIN_EN
    assign diff = {nxt_best[resolution-1], nxt_best} - {nxt_second[resolution-1], nxt_second};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cap         <= '0;
            best        <= '0;
            best_idx    <= '0;
            scan_idx    <= '0;
            class_idx   <= '0;
            class_score <= '0;
`ifdef LAYER_ARGMAX_MARGIN_EN
            second      <= '0;
            margin      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cap      <= zed;
                        best     <= $signed(zed[0]);
                        best_idx <= '0;
                        scan_idx <= IDX_W'(1);
`ifdef LAYER_ARGMAX_MARGIN_EN
                        second   <= MIN_VAL;
`endif
                        if (number_neuron == 1) begin
                            state       <= S_DONE;
                            class_idx   <= '0;
                            class_score <= $signed(zed[0]);
`ifdef LAYER_ARGMAX_MARGIN_EN
                            margin      <= '0;
`endif
                        end else begin
                            state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    best     <= nxt_best;
                    best_idx <= nxt_idx;
                    scan_idx <= scan_idx + IDX_W'(1);
`ifdef LAYER_ARGMAX_MARGIN_EN
                    second   <= nxt_second;
`endif
                    if (last) begin
                        state       <= S_DONE;
                        class_idx   <= nxt_idx;
                        class_score <= nxt_best;
`ifdef LAYER_ARGMAX_MARGIN_EN
                        margin      <= diff[resolution-1:0];
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/layer_argmax.md
# layer_argmax

Sequential arg-max reader on the output side of the final `layer` instance. Captures a layer's `zed` vector with a valid/ready handshake and scans it one neuron per cycle. Presents the winning neuron index (the recognised digit) and its score to the downstream consumer over a second valid/ready handshake.

## Interface
- `number_neuron`, 10, number of neurons (classes) in the vector; must be ≥ 1.
- `resolution`, 8, bit width of each signed `zed` element.
- `IDX_W` (localparam), max(1, $clog2(number_neuron)), width of the class index.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `zed`  in  signed [resolution-1:0] x [number_neuron-1:0]  layer output vector; sampled only at the input handshake.
- `in_valid`  in  1  `zed` holds a complete vector.
- `in_ready`  out  1  block can accept a vector; high only in IDLE.
- `out_valid`  out  1  result registers hold a new result.
- `out_ready`  in  1  consumer accepts the result.
- `class_idx`  out  IDX_W  index of the maximum element.
- `class_score`  out  signed [resolution-1:0]  value of the maximum element.
- `margin`  out  [resolution-1:0] unsigned  best minus second-best. Present only with `LAYER_ARGMAX_MARGIN_EN`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SCAN: compare one element per cycle.
  - DONE: `out_valid`=1.
- IDLE → SCAN/DONE on `in_valid && in_ready`:
  - Copy all of `zed` into an internal capture array.
  - Set best=`zed[0]`, best_idx=0, second=-2^(resolution-1), scan index=1.
  - If number_neuron==1, go directly to DONE.
- SCAN, each cycle, with element e at index i:
  - If e > best (signed, strict): second=best, best=e, best_idx=i.
  - Else if e > second: second=e.
  - Then i=i+1.
  - After comparing index number_neuron-1, load the result registers and go to DONE.
- Tie rule: equal values never replace best, so the lowest index wins. An element equal to best does update second (it fails `e > best` and passes `e > second`).
- DONE → IDLE on `out_valid && out_ready`. `class_idx`, `class_score` and `margin` hold their values after the handshake until the next result load.
- `zed` changes outside the input handshake have no effect on an ongoing scan.
- Arithmetic:
  - All compares are signed at width `resolution`.
  - margin = best - second, computed at resolution+1 bits and truncated to `resolution` unsigned bits. It is never negative.
  - margin = 0 when number_neuron == 1.

## Timing
- Reset values: state=IDLE, `in_ready`=1 in the cycle after reset, `out_valid`=0, `class_idx`=0, `class_score`=0, `margin`=0, capture array cleared.
- Reset asserted in any state returns to IDLE on that edge. A scan or held result is discarded and `out_valid` drops on that edge.
- Latency, with the input handshake on edge k:
  - `out_valid` is high in the cycle after edge k+number_neuron-1.
  - This is 9 cycles for the default of 10.
  - For number_neuron == 1, `out_valid` is high in the cycle after edge k.
- `in_ready` is low in SCAN and DONE. A new vector is accepted no earlier than the cycle after the output handshake, so minimum initiation interval = number_neuron+1 cycles.
- `out_valid` stays high until `out_ready` is sampled high; there is no timeout.
- `in_valid` held high in IDLE is accepted on the first edge. `in_valid` during SCAN or DONE is ignored and not queued.

## Configuration
- `LAYER_ARGMAX_MARGIN_EN` defined:
  - Second-best tracking logic and the `margin` port are compiled in.
  - `margin` is registered together with `class_idx` when the scan completes.
- `LAYER_ARGMAX_MARGIN_EN` not defined:
  - The second-best register, its compare and the `margin` port are absent.
  - All other behaviour and timing are identical.

## Test plan
- Basic winner: N=10, zed={3,-5,7,120,0,1,2,-128,119,4}, `out_ready`=1 → `out_valid` 9 cycles after accept, `class_idx`=3, `class_score`=120, `margin`=1.
- Ties and negatives: zed all -7 → `class_idx`=0, `class_score`=-7, `margin`=0. zed[2]=zed[6]=50, rest -1 → `class_idx`=2, `margin`=0.
- Output backpressure: `out_ready`=0 for 20 cycles after `out_valid` → outputs stable, `in_ready`=0, a new `in_valid` is ignored. Raise `out_ready` for one cycle → IDLE, `in_ready`=1 next cycle; the held result stays unchanged.
- Input isolation: change `zed` every cycle during SCAN → result reflects only the vector captured at the accept edge.
- Reset mid-scan: assert `reset` 4 cycles after accept → next cycle `out_valid`=0, `in_ready`=1, `class_idx`=0. A following vector with zed[9]=127 yields `class_idx`=9.
- Extremes: zed[0]=127, zed[1]=-128, rest 0 → `class_idx`=0, `class_score`=127, `margin`=127. N=1 build with zed={-3} → `out_valid` the cycle after accept, `margin`=0.
